// File: rtl/matrix_scan_controller_pkg.sv
// Shared types and constants for the 5x7 LED matrix column scanner.
package matrix_scan_controller_pkg;

    localparam int unsigned N_COLS    = 5;
    localparam int unsigned N_ROWS    = 7;
    localparam int unsigned FRAME_W   = N_COLS * N_ROWS;
    localparam int unsigned COL_IDX_W = 3;
    localparam int unsigned BRIGHT_W  = 4;

    // Column c occupies bits [7c+6:7c] of the flat frame word.
    typedef logic [N_COLS-1:0][N_ROWS-1:0] frame_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    function automatic logic [N_ROWS-1:0] col_rows(input frame_t frame,
                                                   input logic [COL_IDX_W-1:0] col);
        logic [FRAME_W-1:0] shifted;
        shifted = frame >> (N_ROWS * col);
        return shifted[N_ROWS-1:0];
    endfunction

endpackage

// File: rtl/matrix_scan_controller_if.sv
// Frame transfer channel from the display producer into the scanner.
interface matrix_scan_controller_if;
    import matrix_scan_controller_pkg::*;

    frame_t frame_data;
    logic   frame_valid;
    logic   frame_ready;

    modport master (output frame_data, output frame_valid, input  frame_ready);
    modport slave  (input  frame_data, input  frame_valid, output frame_ready);

endinterface

// File: rtl/matrix_scan_controller_timer.sv
// Loadable down-counter; done while the count sits at zero.
module matrix_scan_controller_timer #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_count,
    output logic             o_done_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_done_c = (r_count == '0);

endmodule

// File: rtl/matrix_scan_controller.sv
// Column scan sequencer for a 5x7 LED matrix: blank/drive per column, PWM
// brightness inside each dwell, double-buffered frames swapped at frame boundary.
module matrix_scan_controller
    import matrix_scan_controller_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 50
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic [BRIGHT_W-1:0]     i_brightness,
    matrix_scan_controller_if.slave frame_if,
    output logic [N_COLS-1:0]       o_coluna_ativa,
    output logic [N_ROWS-1:0]       o_linhas,
    output logic                    o_frame_start
);

    localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned PWM_W   = CNT_W + 4;
    localparam logic [COL_IDX_W-1:0] LAST_COL = COL_IDX_W'(N_COLS - 1);

    scan_state_e r_state, w_state_nxt;

    logic [COL_IDX_W-1:0] r_col, w_col_nxt;
    logic [BRIGHT_W-1:0]  r_bright;
    frame_t               r_display, r_shadow;
    logic                 r_pending;
    logic [N_COLS-1:0]    r_coluna, w_coluna_nxt;
    logic [N_ROWS-1:0]    r_linhas, w_linhas_nxt;
    logic                 r_fstart, w_fstart_nxt;

    logic                 w_tmr_load;
    logic [CNT_W-1:0]     w_tmr_val;
    logic [CNT_W-1:0]     w_tmr_count;
    logic                 w_tmr_done;

    logic                 w_swap;
    logic                 w_capture;
    logic                 w_bright_load;
    logic [PWM_W-1:0]     w_on_cycles;
    logic [PWM_W-1:0]     w_dwell_nxt;
    logic [N_COLS-1:0]    w_onehot;
    logic [N_ROWS-1:0]    w_rows;

    matrix_scan_controller_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_count    (w_tmr_count),
        .o_done_c   (w_tmr_done)
    );

    // PWM compare: dwell position of the next cycle against the lit window
    assign w_on_cycles = ((PWM_W'(r_bright) + PWM_W'(1)) * PWM_W'(DWELL_CYCLES)) >> 4;
    assign w_dwell_nxt = PWM_W'(DWELL_CYCLES) - PWM_W'(w_tmr_count);
    assign w_onehot    = N_COLS'(1) << r_col;
    assign w_rows      = col_rows(r_display, r_col);
    assign w_capture   = frame_if.frame_valid && !r_pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the output values that accompany it on the same edge
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_tmr_load    = 1'b0;
        w_tmr_val     = '0;
        w_coluna_nxt  = '0;
        w_linhas_nxt  = '0;
        w_fstart_nxt  = 1'b0;
        w_swap        = 1'b0;
        w_bright_load = 1'b0;

        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
            w_col_nxt   = '0;
            w_tmr_load  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt  = ST_BLANK;
                    w_col_nxt    = '0;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = CNT_W'(BLANK_CYCLES - 1);
                    w_fstart_nxt = 1'b1;
                end
                ST_BLANK: begin
                    if (w_tmr_done) begin
                        w_state_nxt   = ST_DRIVE;
                        w_tmr_load    = 1'b1;
                        w_tmr_val     = CNT_W'(DWELL_CYCLES - 1);
                        w_bright_load = 1'b1;
                        w_coluna_nxt  = w_onehot;
                        w_linhas_nxt  = w_rows;
                    end
                end
                ST_DRIVE: begin
                    if (w_tmr_done) begin
                        w_state_nxt = ST_BLANK;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = CNT_W'(BLANK_CYCLES - 1);
                        if (r_col == LAST_COL) begin
                            w_col_nxt    = '0;
                            w_fstart_nxt = 1'b1;
                            w_swap       = r_pending;
                        end else begin
                            w_col_nxt = r_col + COL_IDX_W'(1);
                        end
                    end else begin
                        w_coluna_nxt = w_onehot;
                        w_linhas_nxt = (w_dwell_nxt < w_on_cycles) ? w_rows : '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_col_nxt   = '0;
                    w_tmr_load  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col     <= '0;
            r_bright  <= '0;
            r_coluna  <= '0;
            r_linhas  <= '0;
            r_fstart  <= 1'b0;
            r_display <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            r_col    <= w_col_nxt;
            r_coluna <= w_coluna_nxt;
            r_linhas <= w_linhas_nxt;
            r_fstart <= w_fstart_nxt;
            if (w_bright_load) begin
                r_bright <= i_brightness;
            end
            // Capture needs pending low and swap needs it high, so they never collide
            if (w_capture) begin
                r_shadow  <= frame_if.frame_data;
                r_pending <= 1'b1;
            end else if (w_swap) begin
                r_display <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    assign frame_if.frame_ready = !r_pending;
    assign o_coluna_ativa       = r_coluna;
    assign o_linhas             = r_linhas;
    assign o_frame_start        = r_fstart;

endmodule
